// File: rtl/pack_pkg.sv
// Shared pack layout for the video pack switch: field positions, the pack type and the RGB mask.
// The RGB mask is used only when PACK_SWITCH_BLANK_EN is defined.
package pack_pkg;

    localparam int PACK_W   = 49;

    localparam int PCLK_BIT = 48;
    localparam int HS_BIT   = 47;
    localparam int VS_BIT   = 46;
    localparam int DE_BIT   = 45;

    localparam int RGB_HI   = 44;
    localparam int RGB_LO   = 21;
    localparam int RGB_W    = RGB_HI - RGB_LO + 1;

    localparam int X_HI     = 20;
    localparam int X_LO     = 10;
    localparam int Y_HI     = 9;
    localparam int Y_LO     = 0;

    typedef logic [PACK_W-1:0] pack_t;

    // Ones over the 24 colour bits; sync, de and coordinates stay outside the mask
    localparam pack_t RGB_MASK = pack_t'({RGB_W{1'b1}}) << RGB_LO;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a 1-cycle press pulse.
// The press pulse appears DEB_TICKS+3 cycles after a clean key edge.
module key_debounce #(
    parameter int DEB_TICKS = 500_000
)(
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_TICKS + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             sync3_reg;
    logic             stable_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            sync3_reg  <= 1'b0;
            stable_reg <= 1'b0;
            press_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= key;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
            press_reg <= 1'b0;
            // Any change restarts the count; the count saturates once the level is trusted
            if (sync2_reg != sync3_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_W'(DEB_TICKS - 1)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (sync2_reg != stable_reg) begin
                stable_reg <= sync2_reg;
                press_reg  <= sync2_reg;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/pack_switch_n.sv
// N-channel video pack switch; channel changes commit only on a vsync rising edge of the live channel.
// Optional macro PACK_SWITCH_BLANK_EN blanks RGB for the first frame after every commit.
module pack_switch_n #(
    parameter int N_CH          = 4,
    parameter int PACK_W        = pack_pkg::PACK_W,
    parameter int VS_BIT        = pack_pkg::VS_BIT,
    parameter int DEB_TICKS     = 500_000,
    parameter int FRAMES_PER_CH = 60,
    localparam int SEL_W        = $clog2(N_CH)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key,
    input  logic                   auto_en,
    input  logic [N_CH*PACK_W-1:0] i_packs,
    output logic [PACK_W-1:0]      o_pack,
    output logic [SEL_W-1:0]       sel,
    output logic                   pending
);

    import pack_pkg::*;

    localparam int CNT_W = (FRAMES_PER_CH > 1) ? $clog2(FRAMES_PER_CH) : 1;

    if (N_CH < 2 || N_CH > 16) begin : g_bad_nch
        $error("pack_switch_n: N_CH must be in 2..16");
    end
    if (FRAMES_PER_CH < 1) begin : g_bad_frames
        $error("pack_switch_n: FRAMES_PER_CH must be at least 1");
    end
    if (DEB_TICKS < 1) begin : g_bad_deb
        $error("pack_switch_n: DEB_TICKS must be at least 1");
    end
    if (VS_BIT >= PACK_W) begin : g_bad_vs
        $error("pack_switch_n: VS_BIT must lie inside the pack");
    end

    logic [PACK_W-1:0] pack_arr [N_CH];

    genvar gi;
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign pack_arr[gi] = i_packs[gi*PACK_W +: PACK_W];
    end

    logic [SEL_W-1:0]  sel_reg;
    logic [SEL_W-1:0]  target_reg;
    logic              pending_reg;
    logic              vs_prev_reg;
    logic [CNT_W-1:0]  frame_cnt_reg;
    logic [PACK_W-1:0] o_pack_reg;

    logic              press;
    logic              vs_now;
    logic              vs_rise;
    logic              auto_hit;
    logic              commit;
    logic [SEL_W-1:0]  new_sel;
    logic [SEL_W-1:0]  base_sel;
    logic [SEL_W-1:0]  base_target;
    logic [SEL_W-1:0]  press_target;
    logic [PACK_W-1:0] mux_pack;
    logic [PACK_W-1:0] out_next;

    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
        return (c == SEL_W'(N_CH - 1)) ? '0 : c + SEL_W'(1);
    endfunction

    key_debounce #(
        .DEB_TICKS (DEB_TICKS)
    ) u_key_debounce (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .press (press)
    );

    // A press landing on a commit edge builds on the post-commit channel
    always_comb begin
        mux_pack     = pack_arr[sel_reg];
        vs_now       = mux_pack[VS_BIT];
        vs_rise      = vs_now & ~vs_prev_reg;
        auto_hit     = auto_en & vs_rise & (frame_cnt_reg == CNT_W'(FRAMES_PER_CH - 1));
        commit       = vs_rise & (pending_reg | auto_hit);
        new_sel      = auto_hit ? next_ch(sel_reg) : target_reg;
        base_sel     = commit ? new_sel : sel_reg;
        base_target  = commit ? new_sel : target_reg;
        press_target = next_ch(base_target);
    end

`ifdef PACK_SWITCH_BLANK_EN
    logic blank_reg;

    always_comb begin
        out_next = mux_pack;
        if (blank_reg && !vs_rise) begin
            out_next = mux_pack & ~PACK_W'(RGB_MASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_reg <= 1'b0;
        end else if (commit) begin
            blank_reg <= 1'b1;
        end else if (vs_rise) begin
            blank_reg <= 1'b0;
        end
    end
`else
    always_comb begin
        out_next = mux_pack;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg       <= '0;
            target_reg    <= '0;
            pending_reg   <= 1'b0;
            vs_prev_reg   <= 1'b0;
            frame_cnt_reg <= '0;
            o_pack_reg    <= '0;
        end else begin
            o_pack_reg <= out_next;
            // Reload history from the incoming channel so the switch itself is not seen as an edge
            vs_prev_reg <= commit ? pack_arr[new_sel][VS_BIT] : vs_now;
            if (commit) begin
                sel_reg <= new_sel;
            end
            if (commit || !auto_en) begin
                frame_cnt_reg <= '0;
            end else if (vs_rise) begin
                frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end
            if (press) begin
                target_reg  <= press_target;
                pending_reg <= (press_target != base_sel);
            end else if (commit) begin
                target_reg  <= new_sel;
                pending_reg <= 1'b0;
            end
        end
    end

    assign o_pack  = o_pack_reg;
    assign sel     = sel_reg;
    assign pending = pending_reg;

endmodule

// File: tb/tb_pack_switch_n.sv
// Randomised self-checking bench for pack_switch_n against a cycle-level behavioural model.
// Honours PACK_SWITCH_BLANK_EN in the model when the macro is defined.
module tb_pack_switch_n;

    import pack_pkg::*;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int F  = 2;
    localparam int W  = PACK_W;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          key;
    logic          auto_en;
    logic [N*W-1:0] i_packs;
    logic [W-1:0]  o_pack;
    logic [SW-1:0] sel;
    logic          pending;

    pack_switch_n #(
        .N_CH          (N),
        .PACK_W        (W),
        .VS_BIT        (VS_BIT),
        .DEB_TICKS     (D),
        .FRAMES_PER_CH (F)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .auto_en (auto_en),
        .i_packs (i_packs),
        .o_pack  (o_pack),
        .sel     (sel),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Stimulus sources
    logic [W-1:0] pk [N];
    int  ch_per [N];
    int  ch_cnt [N];
    bit  vs_mode;
    bit  vs_lvl;

    // Behavioural model state
    int           m_sel, m_tgt, m_cnt;
    bit           m_pend;
    logic [W-1:0] m_out;
    bit           prev_vs [N];
    bit           hist_ok;
    bit           key_hist [$];
`ifdef PACK_SWITCH_BLANK_EN
    bit           m_blank;
`endif

    // Debounced press reaches the switch on edge n iff the key was sampled high on the
    // D+1 edges n-D-3..n-3 and low just before that run.
    task automatic model_step();
        bit pr, vs_rise, auto_hit, commit;
        int n, ns;
        n = key_hist.size();
        key_hist.push_back(rst ? 1'b0 : key);
        pr = 1'b0;
        if (n >= D + 3) begin
            pr = 1'b1;
            for (int j = n - D - 3; j <= n - 3; j++) if (!key_hist[j]) pr = 1'b0;
            if (n - D - 4 >= 0 && key_hist[n-D-4]) pr = 1'b0;
        end
        if (rst) begin
            m_sel = 0; m_tgt = 0; m_pend = 1'b0; m_cnt = 0; m_out = '0; hist_ok = 1'b0;
`ifdef PACK_SWITCH_BLANK_EN
            m_blank = 1'b0;
`endif
        end else begin
            vs_rise  = pk[m_sel][VS_BIT] && !(hist_ok && prev_vs[m_sel]);
            auto_hit = auto_en && vs_rise && (m_cnt == F - 1);
            commit   = vs_rise && (m_pend || auto_hit);
            m_out    = pk[m_sel];
`ifdef PACK_SWITCH_BLANK_EN
            if (m_blank && !vs_rise) m_out[RGB_HI:RGB_LO] = '0;
            if (commit) m_blank = 1'b1;
            else if (vs_rise) m_blank = 1'b0;
`endif
            if (commit) begin
                ns = auto_hit ? (m_sel + 1) % N : m_tgt;
                m_sel = ns; m_tgt = ns; m_pend = 1'b0; m_cnt = 0;
            end else if (!auto_en) begin
                m_cnt = 0;
            end else if (vs_rise) begin
                m_cnt++;
            end
            if (pr) begin
                m_tgt  = (m_tgt + 1) % N;
                m_pend = (m_tgt != m_sel);
            end
            hist_ok = 1'b1;
        end
        for (int k = 0; k < N; k++) prev_vs[k] = pk[k][VS_BIT];
    endtask

    task automatic tick();
        logic [63:0] r;
        for (int k = 0; k < N; k++) begin
            r = {$urandom(), $urandom()};
            pk[k] = r[W-1:0];
            pk[k][VS_BIT] = vs_mode ? (ch_cnt[k] < 2) : vs_lvl;
            i_packs[k*W +: W] = pk[k];
            ch_cnt[k] = (ch_cnt[k] + 1) % ch_per[k];
        end
        @(posedge clk);
        model_step();
        #1;
        check_eq("sel", 64'(sel), 64'(m_sel));
        check_eq("pending", 64'(pending), 64'(m_pend));
        check_eq("o_pack", 64'(o_pack), 64'(m_out));
    endtask

    task automatic press_key();
        key = 1'b1;
        repeat (D + 6) tick();
        key = 1'b0;
        repeat (D + 6) tick();
        $display("press: sel=%0d pending=%0d", sel, pending);
    endtask

    task automatic vs_pulse();
        vs_lvl = 1'b1;
        tick();
        tick();
        vs_lvl = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        $display("reset: sel=%0d pending=%0d", sel, pending);
    endtask

    initial begin
        rst = 1'b1; key = 1'b0; auto_en = 1'b0; vs_mode = 1'b0; vs_lvl = 1'b0;
        for (int k = 0; k < N; k++) begin
            ch_per[k] = $urandom_range(12, 30);
            ch_cnt[k] = $urandom_range(0, ch_per[k] - 1);
        end
        repeat (3) tick();
        check_eq("rst_sel", 64'(sel), 64'd0);
        check_eq("rst_pending", 64'(pending), 64'd0);
        check_eq("rst_o_pack", 64'(o_pack), 64'd0);
        rst = 1'b0;

        // Frames on all channels with no request: stay on channel 0
        repeat (3) vs_pulse();
        check_eq("idle_sel", 64'(sel), 64'd0);

        // One clean press mid-frame, committed on the next frame edge
        key = 1'b1;
        repeat (D + 3) tick();
        check_eq("press_early", 64'(pending), 64'd0);
        tick();
        check_eq("press_latency", 64'(pending), 64'd1);
        check_eq("press_sel_hold", 64'(sel), 64'd0);
        repeat (2) tick();
        key = 1'b0;
        repeat (D + 6) tick();
        check_eq("no_commit_midframe", 64'(sel), 64'd0);
        vs_lvl = 1'b1;
        tick();
        check_eq("commit_sel", 64'(sel), 64'd1);
        check_eq("commit_pending", 64'(pending), 64'd0);
        tick();
        vs_lvl = 1'b0;
        repeat (3) tick();
        $display("single press committed: sel=%0d", sel);

        // Four presses wrap the target back to the live channel
        for (int i = 0; i < 4; i++) begin
            press_key();
            check_eq("wrap_pending", 64'(pending), (i < 3) ? 64'd1 : 64'd0);
        end
        vs_pulse();
        check_eq("wrap_no_switch", 64'(sel), 64'd1);

        // Reset while a request is pending discards it
        press_key();
        check_eq("pre_reset_pending", 64'(pending), 64'd1);
        do_reset();
        check_eq("reset_sel", 64'(sel), 64'd0);
        check_eq("reset_pending", 64'(pending), 64'd0);

        // Press landing on the frame edge while pending with target 2
        press_key();
        press_key();
        key = 1'b1;
        repeat (D + 3) tick();
        vs_lvl = 1'b1;
        tick();
        check_eq("coinc_sel", 64'(sel), 64'd2);
        check_eq("coinc_pending", 64'(pending), 64'd1);
        tick();
        vs_lvl = 1'b0;
        key = 1'b0;
        repeat (D + 6) tick();
        vs_pulse();
        check_eq("coinc_next_sel", 64'(sel), 64'd3);
        check_eq("coinc_next_pending", 64'(pending), 64'd0);

        // Auto-scan: advance every F frame edges starting from channel 3
        auto_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vs_pulse();
            check_eq("auto_sel", 64'(sel), 64'((3 + i / F) % N));
            $display("auto frame %0d: sel=%0d", i, sel);
        end
        auto_en = 1'b0;
        repeat (3) tick();

        // Randomised traffic with independent frame timing per channel
        vs_mode = 1'b1;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    key = 1'b1;
                    repeat (D + 2 + $urandom_range(0, 5)) tick();
                    key = 1'b0;
                    repeat (D + 4 + $urandom_range(0, 5)) tick();
                    $display("rand %0d press: sel=%0d pending=%0d", it, sel, pending);
                end
                3: begin
                    key = 1'b1;
                    repeat ($urandom_range(1, D - 1)) tick();
                    key = 1'b0;
                    repeat (D + 4) tick();
                    $display("rand %0d glitch: sel=%0d pending=%0d", it, sel, pending);
                end
                4: begin
                    auto_en = ~auto_en;
                    tick();
                    $display("rand %0d auto_en=%0d", it, auto_en);
                end
                5: begin
                    if ($urandom_range(0, 3) == 0) do_reset();
                    else tick();
                end
                default: begin
                    repeat ($urandom_range(1, 20)) tick();
                    $display("rand %0d idle: sel=%0d pending=%0d", it, sel, pending);
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
